// File: rtl/sample_ctrl_pkg.sv
// Shared definitions for the sample strobe controller: FSM state encoding and mode constants.
package sample_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_ARMED = 3'd2,
        ST_BURST = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/sample_decimator.sv
// Decimation counter: flags every period-th valid as qualifying. period must already be nonzero.
module sample_decimator #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear,
    input  logic                 valid,
    input  logic [CNT_WIDTH-1:0] period,
    output logic                 qualify
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] last;

    assign last    = period - ONE;
    assign qualify = valid && (cnt_q == last);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (valid) begin
            cnt_q <= qualify ? '0 : cnt_q + ONE;
        end
    end

endmodule

// File: rtl/sample_strobe_ctrl.sv
// Gates an upstream sample stream into a sample-and-hold, either continuously decimated
// or as a triggered burst of a programmed length.
module sample_strobe_ctrl
    import sample_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 mode_i,
    input  logic [CNT_WIDTH-1:0] period_i,
    input  logic [CNT_WIDTH-1:0] burst_len_i,
    input  logic                 arm_i,
    input  logic                 trigger_i,
    input  logic                 data_valid_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic                 data_valid_o,
    output logic [WIDTH-1:0]     data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] sample_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] period_q, burst_q;
    logic                 mode_q;
    logic                 trig_q;
    logic                 latch;
    logic                 entry;
    logic                 active_q, active_d;
    logic                 dec_valid;
    logic                 qualify;
    logic                 trig_rise;
    logic                 burst_last;
    logic [CNT_WIDTH:0]   cnt_inc;

    assign active_q   = (state_q == ST_RUN) || (state_q == ST_BURST);
    assign active_d   = (state_d == ST_RUN) || (state_d == ST_BURST);
    assign entry      = active_d && !active_q;
    assign dec_valid  = enable_i && active_q && data_valid_i;
    assign trig_rise  = trigger_i && !trig_q;
    assign cnt_inc    = {1'b0, sample_cnt_o} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign burst_last = (state_q == ST_BURST) && qualify && (cnt_inc == {1'b0, burst_q});

    sample_decimator #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_decimator (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear   (entry),
        .valid   (dec_valid),
        .period  (period_q),
        .qualify (qualify)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A re-arm latched as continuous mode starts free-running on the trigger edge.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mode_i == MODE_CONT) begin
                        state_d = ST_RUN;
                        latch   = 1'b1;
                    end else if (arm_i) begin
                        state_d = ST_ARMED;
                        latch   = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (trig_rise) begin
                        state_d = (mode_q == MODE_BURST) ? ST_BURST : ST_RUN;
                    end
                end
                ST_BURST: begin
                    if (burst_last) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (arm_i) begin
                        state_d = ST_ARMED;
                        latch   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            ST_RUN, ST_ARMED, ST_BURST: busy_o = 1'b1;
            ST_DONE:                    done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_q <= ONE;
            burst_q  <= ONE;
            mode_q   <= MODE_CONT;
        end else if (latch) begin
            period_q <= (period_i == '0) ? ONE : period_i;
            burst_q  <= (burst_len_i == '0) ? ONE : burst_len_i;
            mode_q   <= mode_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trig_q       <= 1'b0;
            data_valid_o <= 1'b0;
            data_o       <= '0;
            sample_cnt_o <= '0;
        end else begin
            trig_q       <= trigger_i;
            data_valid_o <= qualify;
            if (qualify) begin
                data_o <= data_i;
            end
            if (entry) begin
                sample_cnt_o <= '0;
            end else if (qualify && (sample_cnt_o != '1)) begin
                sample_cnt_o <= sample_cnt_o + ONE;
            end
        end
    end

endmodule

// File: tb/tb_sample_strobe_ctrl.sv
// Scoreboard bench for sample_strobe_ctrl against a behavioural model of the sampling rules.
module tb_sample_strobe_ctrl;

    localparam int W  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0, mode = 1'b0, arm = 1'b0, trig = 1'b0, dv = 1'b0;
    logic [CW-1:0] period = '0, burst_len = '0;
    logic [W-1:0]  data = '0;
    logic          dvo, busy, done;
    logic [W-1:0]  dout;
    logic [CW-1:0] scnt;

    int unsigned n_cmp = 0, n_bad = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sample_strobe_ctrl #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .mode_i       (mode),
        .period_i     (period),
        .burst_len_i  (burst_len),
        .arm_i        (arm),
        .trigger_i    (trig),
        .data_valid_i (dv),
        .data_i       (data),
        .data_valid_o (dvo),
        .data_o       (dout),
        .busy_o       (busy),
        .done_o       (done),
        .sample_cnt_o (scnt)
    );

    typedef struct {int cyc; logic [W-1:0] d;} exp_t;
    exp_t exp_q[$];

    // Reference model: phase name, latched settings, valids seen and samples emitted since entry.
    string       ph = "IDLE";
    int unsigned per_l = 1, len_l = 1, vcnt = 0, emitted = 0;
    bit          mode_l = 0, trig_prev = 0;
    logic [W-1:0] last_d = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic latch_settings();
        per_l  = (period == 0) ? 1 : int'(period);
        len_l  = (burst_len == 0) ? 1 : int'(burst_len);
        mode_l = mode;
    endtask

    task automatic model_step();
        string nxt = ph;
        bit    emit = 0;
        exp_t  e;
        data = W'($urandom);
        if (enable && (ph == "RUN" || ph == "BURST") && dv) begin
            vcnt++;
            if (vcnt % per_l == 0) begin
                emit = 1;
                emitted++;
                e.cyc = cyc + 1;
                e.d   = data;
                exp_q.push_back(e);
            end
        end
        if (!enable) nxt = "IDLE";
        else if (ph == "IDLE") begin
            if (!mode) begin nxt = "RUN"; latch_settings(); vcnt = 0; emitted = 0; end
            else if (arm) begin nxt = "ARMED"; latch_settings(); end
        end else if (ph == "ARMED") begin
            if (trig && !trig_prev) begin nxt = mode_l ? "BURST" : "RUN"; vcnt = 0; emitted = 0; end
        end else if (ph == "BURST") begin
            if (emit && emitted == len_l) nxt = "DONE";
        end else if (ph == "DONE") begin
            if (arm) begin nxt = "ARMED"; latch_settings(); end
        end
        trig_prev = trig;
        ph = nxt;
        if (emit) last_d = data;
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic tick();
        model_step();
        @(posedge clk); #1;
        check("busy", busy, (ph == "RUN" || ph == "ARMED" || ph == "BURST"));
        check("done", done, ph == "DONE");
        check("sample_cnt", scnt, emitted);
        check("data_hold", dout, last_d);
        @(negedge clk);
    endtask

    task automatic drv(input bit en, input bit ar, input bit tr, input bit v);
        enable = en; arm = ar; trig = tr; dv = v;
        tick();
    endtask

    task automatic start_burst();
        drv(1, 1, 0, 0);
        drv(1, 0, 0, 0);
        drv(1, 0, 1, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (dvo) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    check("pulse_data", dout, e.d);
                end else begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_pulse: data_valid_o=1 at cycle %0d, required 0", cyc);
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL missing_pulse: data_valid_o=0 at cycle %0d, required 1", e.cyc);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dvo", dvo, 0);
        check("rst_data", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", scnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Continuous, period 4, 16 back-to-back valids.
        mode = 0; period = 4; burst_len = 0;
        drv(1, 0, 0, 0);
        repeat (16) drv(1, 0, 0, 1);
        check("cont_count", scnt, 4);
        drv(0, 0, 0, 0);

        // Continuous with random valids; live period/mode changes must be ignored.
        for (int r = 0; r < 3; r++) begin
            mode = 0; period = CW'((r == 0) ? 0 : $urandom_range(2, 5));
            drv(1, 0, 0, 0);
            for (int i = 0; i < 30; i++) begin
                period = CW'($urandom); mode = 1'($urandom);
                drv(1, 0, 0, 1'($urandom));
            end
            mode = 0;
            drv(0, 0, 0, 0);
        end

        // Basic burst: period 1, length 3.
        mode = 1; period = 1; burst_len = 3;
        start_burst();
        repeat (10) drv(1, 0, 1, 1);
        check("burst_done", done, 1);
        check("burst_busy", busy, 0);
        drv(0, 0, 0, 0);

        // Zero period and length behave as 1.
        period = 0; burst_len = 0;
        start_burst();
        repeat (5) drv(1, 0, 0, 1);
        check("zero_cnt", scnt, 1);
        check("zero_done", done, 1);
        drv(0, 0, 0, 0);

        // Trigger held high through arming: needs a fresh rising edge.
        period = 1; burst_len = 2;
        drv(1, 0, 1, 1);
        drv(1, 1, 1, 1);
        period = 3;
        repeat (3) drv(1, 0, 1, 1);
        drv(1, 0, 0, 1);
        drv(1, 0, 1, 1);
        repeat (4) drv(1, 0, 0, 1);
        check("trig_cnt", scnt, 2);
        drv(0, 0, 0, 0);

        // Abort after 2 of 5 samples, then a full burst.
        period = 1; burst_len = 5;
        start_burst();
        repeat (2) drv(1, 0, 0, 1);
        repeat (4) drv(0, 0, 0, 1);
        check("abort_busy", busy, 0);
        start_burst();
        repeat (8) drv(1, 0, 0, 1);
        check("full_cnt", scnt, 5);
        drv(0, 0, 0, 0);

        // Random bursts with a re-arm from DONE.
        for (int r = 0; r < 4; r++) begin
            mode = 1; period = CW'($urandom_range(0, 3)); burst_len = CW'($urandom_range(0, 6));
            start_burst();
            for (int i = 0; i < 30; i++) drv(1, 0, 1'($urandom), 1'($urandom));
            period = CW'($urandom_range(0, 3)); burst_len = CW'($urandom_range(0, 6));
            start_burst();
            for (int i = 0; i < 30; i++) drv(1, 0, 1'($urandom), 1'($urandom_range(0, 3) != 0));
            drv(0, 0, 0, 0);
        end

        // Reset mid-burst, right after a pulse has been registered.
        mode = 1; period = 1; burst_len = 5;
        start_burst();
        repeat (2) drv(1, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_dvo", dvo, 0);
        check("mid_rst_data", dout, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_cnt", scnt, 0);
        ph = "IDLE"; vcnt = 0; emitted = 0; trig_prev = 0; last_d = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) drv(1, 0, 0, 1);
        drv(1, 0, 1, 1);
        repeat (3) drv(1, 0, 0, 1);
        drv(0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_strobe_ctrl.md
SAMPLE_STROBE_CTRL -- requirements
Module: sample_strobe_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width, matching the downstream sample-and-hold.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the period, burst and count fields.
REQ-003 SHALL have port clk_i, input, 1: the single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port enable_i, input, 1: global run enable.
REQ-006 SHALL have port mode_i, input, 1: 0 = CONTINUOUS, 1 = BURST.
REQ-007 SHALL have port period_i, input, CNT_WIDTH: decimation factor.
REQ-008 SHALL have port burst_len_i, input, CNT_WIDTH: number of samples per burst.
REQ-009 SHALL have port arm_i, input, 1: level, arms a burst.
REQ-010 SHALL have port trigger_i, input, 1: level; its rising edge starts an armed burst.
REQ-011 SHALL have port data_valid_i, input, 1: upstream sample strobe.
REQ-012 SHALL have port data_i, input, WIDTH: upstream sample.
REQ-013 SHALL have port data_valid_o, output, 1: gated strobe to the sample-and-hold.
REQ-014 SHALL have port data_o, output, WIDTH: gated sample.
REQ-015 SHALL have port busy_o, output, 1: high in RUN, ARMED or BURST.
REQ-016 SHALL have port done_o, output, 1: high in DONE.
REQ-017 SHALL have port sample_cnt_o, output, CNT_WIDTH: number of samples emitted since the last RUN/BURST entry, saturating.

Function
REQ-018 SHALL implement the states IDLE, RUN, ARMED, BURST and DONE.
REQ-019 SHALL transition from IDLE as follows: enable_i & mode_i=0 -> RUN; enable_i & mode_i=1 & arm_i -> ARMED.
REQ-020 SHALL, in ARMED, go to BURST on a trigger rising edge (trigger_i=1 and previous-cycle trigger_i=0).
REQ-021 SHALL go from BURST to DONE in the cycle the emitted count reaches the latched burst length.
REQ-022 SHALL go from DONE to ARMED on arm_i.
REQ-023 SHALL return to IDLE from any state in the next cycle when enable_i=0; enable_i takes priority over all other events.
REQ-024 SHALL latch period_i, burst_len_i and mode_i on leaving IDLE and on DONE->ARMED; later changes are ignored until the next such event.
REQ-025 SHALL treat a latched period or burst length of 0 as 1.
REQ-026 SHALL keep a decimation counter that increments on each data_valid_i in RUN or BURST; a valid is qualifying when the counter equals period-1, and the counter then wraps to 0.
REQ-027 SHALL clear the decimation counter on entry to RUN or BURST.
REQ-028 SHALL, for a qualifying valid, assert data_valid_o for exactly one cycle, one cycle after data_valid_i, with data_o equal to that data_i (registered, latency 1).
REQ-029 SHALL hold data_o at its last emitted value at all other times.
REQ-030 SHALL never emit a sample in IDLE, ARMED or DONE.
REQ-031 SHALL not sample in the trigger cycle itself (ARMED->BURST); the first candidate valid is the following cycle.
REQ-032 SHALL emit the final burst sample (count reaching the length) and enter DONE in the same clock edge; further valids are not emitted.
REQ-033 SHALL clear sample_cnt_o on entry to RUN or BURST and saturate it at all-ones.
REQ-034 SHALL, on enable_i deassertion during BURST, emit no further samples; a data_valid_o already registered still completes its single cycle.

Reset
REQ-035 SHALL, on rst_ni low, asynchronously force state IDLE, data_valid_o=0, data_o=0, busy_o=0, done_o=0, sample_cnt_o=0, decimation counter=0 and trigger history=0.
REQ-036 SHALL, on a reset asserted mid-burst, abort the burst; after release it requires a fresh arm_i and trigger_i.

Structure
REQ-037 SHALL take the state encodings (3 bits) and the mode constants MODE_CONT and MODE_BURST from the shared package sample_ctrl_pkg.
REQ-038 SHALL place the decimation counter and qualify logic in the sub-module sample_decimator (inputs clear, valid, period; output qualify); the FSM and output registers remain in the top module.

Verification
REQ-039 SHALL verify continuous decimation: mode 0, period 4, valid every cycle for 16 cycles -> 4 pulses, on input valids #4, #8, #12 and #16, each delayed 1 cycle; sample_cnt_o=4.
REQ-040 SHALL verify a basic burst: mode 1, period 1, burst 3, arm, trigger edge, 10 valids -> exactly 3 pulses, then done_o=1 and busy_o=0.
REQ-041 SHALL verify the zero boundary: period 0 and burst 0 -> behaves as 1/1, with exactly one pulse, then DONE.
REQ-042 SHALL verify the trigger edge: trigger held high before arm -> no burst until trigger falls and rises again; a valid in the trigger cycle is not emitted.
REQ-043 SHALL verify abort: enable_i dropped after 2 of 5 burst samples -> IDLE next cycle with no further pulses; re-enable, arm and trigger -> a full 5-sample burst.
REQ-044 SHALL verify reset mid-burst: rst_ni low -> all outputs 0 immediately; after release, valids with no arm produce no pulses.
